// File: rtl/rs232_tx.sv
// 8N1 UART transmitter: valid/ready byte FIFO feeding a start/data/stop serialiser.
// TX idles high; frames are sent back-to-back while the FIFO holds data.
module rs232_tx #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       TX,
  output logic       busy
);

  localparam int PERIOD = CLK_HZ / BAUD;
  localparam int BW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(PERIOD - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          w_push, w_pop, w_empty, w_wrap, w_shift, w_tx_nxt;

  // ready deliberately ignores a same-cycle pop so it depends on count alone
  assign ready   = (r_count != CNT_FULL);
  assign w_push  = valid && ready;
  assign w_empty = (r_count == '0);
  assign w_wrap  = (r_baud == BAUD_LAST);
  assign TX      = r_tx;
  assign busy    = (r_state != S_IDLE) || !w_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_state_nxt = S_START;
      S_START: if (w_wrap) w_state_nxt = S_DATA;
      S_DATA:  if (w_wrap && r_bit == 3'd7) w_state_nxt = S_STOP;
      S_STOP:  if (w_wrap) w_state_nxt = w_empty ? S_IDLE : S_START;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop    = 1'b0;
    w_shift  = 1'b0;
    w_tx_nxt = r_tx;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop    = 1'b1;
          w_tx_nxt = 1'b0;
        end
      end
      S_START: if (w_wrap) w_tx_nxt = r_shift[0];
      S_DATA: begin
        if (w_wrap) begin
          if (r_bit == 3'd7) begin
            w_tx_nxt = 1'b1;
          end else begin
            w_shift  = 1'b1;
            w_tx_nxt = r_shift[1];
          end
        end
      end
      S_STOP: begin
        if (w_wrap) begin
          w_pop    = !w_empty;
          w_tx_nxt = w_empty;
        end
      end
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_tx <= w_tx_nxt;
      if (r_state == S_IDLE || w_wrap) r_baud <= '0;
      else                             r_baud <= r_baud + 1'b1;
      if (r_state != S_DATA) r_bit <= '0;
      else if (w_wrap)       r_bit <= r_bit + 1'b1;
      if (w_pop)        r_shift <= r_mem[r_rd_ptr];
      else if (w_shift) r_shift <= {1'b0, r_shift[7:1]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data;
  end

endmodule

// File: tb/tb_rs232_tx.sv
// Directed bench for rs232_tx with a behavioural serial receiver on TX.
// Uses a short bit period (16 clocks) so every scenario runs quickly.
module tb_rs232_tx;

  localparam int P     = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready, TX, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int max_cnt  = 0;
  logic [8:0] rx_q[$];
  int         st_q[$];

  rs232_tx #(.CLK_HZ(160000), .BAUD(10000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .data(data), .valid(valid),
    .ready(ready), .TX(TX), .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (int'(dut.r_count) > max_cnt) max_cnt = int'(dut.r_count);
  end

  // Receiver: mid-bit sampling, queue holds {stop, byte} and the start cycle
  initial begin
    logic [7:0] b;
    int st;
    forever begin
      @(negedge clk);
      if (resetn && TX == 1'b0) begin
        st = cyc;
        repeat (P/2) @(negedge clk);
        if (TX == 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (P) @(negedge clk);
            b[i] = TX;
          end
          repeat (P) @(negedge clk);
          rx_q.push_back({TX, b});
          st_q.push_back(st);
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int k = 0; k < budget && rx_q.size() < n; k++) @(negedge clk);
    check_val("rx_count", rx_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget && busy; k++) @(negedge clk);
    check_val("idle_reached", busy, 1'b0);
  endtask

  initial begin
    int bad, acc, idx;
    logic prev;
    logic [7:0] frame_bits [10];
    logic [9:0] pat;

    // 1: reset behaviour
    repeat (2) @(negedge clk);
    check_val("rst_tx", TX, 1'b1);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_ready", ready, 1'b1);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (TX !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) bad++;
    end
    check_val("idle_stable", bad, 0);

    // 2: single byte 0x31, exact bit timing
    pat = 10'b1_00110001_0;
    data = 8'h31; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check_val("tx_before_pop", TX, 1'b1);
    for (int i = 0; i < 10; i++) begin
      bad = 0;
      for (int k = 0; k < P; k++) begin
        @(negedge clk);
        if (TX === pat[i]) bad++;
      end
      check_val($sformatf("bit%0d_len", i), bad, P);
    end
    check_val("busy_in_stop", busy, 1'b1);
    @(negedge clk);
    check_val("busy_after", busy, 1'b0);
    wait_rx(1, 4*P);
    if (rx_q.size() > 0) check_val("rx_31", rx_q[0], 9'h131);
    rx_q.delete(); st_q.delete();

    // 3: five back-to-back bytes, contiguous frames
    for (int i = 0; i < 5; i++) begin
      data = 8'(8'h31 + i); valid = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    wait_rx(5, 60*P);
    for (int i = 0; i < 5 && i < rx_q.size(); i++)
      check_val($sformatf("loop_%0d", i), rx_q[i], 9'h100 | (9'h31 + 9'(i)));
    for (int i = 1; i < 5 && i < st_q.size(); i++)
      check_val($sformatf("gap_%0d", i), st_q[i] - st_q[i-1], 10*P);
    wait_idle(20*P);
    rx_q.delete(); st_q.delete();

    // 4: FIFO full under held valid
    acc = 0;
    data = 8'hA0; valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      prev = ready;
      @(negedge clk);
      if (prev) begin
        acc++;
        data = 8'(8'hA0 + acc);
      end
    end
    valid = 1'b0;
    check_val("full_accepted", acc, 5);
    check_val("full_ready", ready, 1'b0);
    prev = TX;
    for (int k = 0; k < 12*P && !ready; k++) begin
      prev = TX;
      @(negedge clk);
    end
    check_val("ready_rise", {prev, TX}, 2'b10);
    wait_rx(5, 60*P);
    wait_idle(60*P);
    repeat (2*P) @(negedge clk);
    check_val("full_rx_total", rx_q.size(), 5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++)
      check_val($sformatf("full_%0d", i), rx_q[i], 9'h100 | (9'hA0 + 9'(i)));
    rx_q.delete(); st_q.delete();

    // 5: reset during data bit 3
    data = 8'hFF; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (4*P + P/2) @(negedge clk);
    check_val("pre_rst_busy", busy, 1'b1);
    resetn = 1'b0;
    #1;
    check_val("mid_rst_tx", TX, 1'b1);
    check_val("mid_rst_busy", busy, 1'b0);
    check_val("mid_rst_ready", ready, 1'b1);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    bad = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (TX !== 1'b1 || busy !== 1'b0) bad++;
    end
    check_val("post_rst_idle", bad, 0);
    rx_q.delete(); st_q.delete();

    // 6: pointer wrap, 12 bytes under backpressure
    max_cnt = 0;
    idx = 0;
    data = 8'h00; valid = 1'b1;
    for (int k = 0; k < 150*P && idx < 3*DEPTH; k++) begin
      prev = ready;
      @(negedge clk);
      if (prev) begin
        idx++;
        data = 8'(idx);
      end
    end
    valid = 1'b0;
    check_val("wrap_pushed", idx, 3*DEPTH);
    wait_rx(3*DEPTH, 80*P);
    for (int i = 0; i < 3*DEPTH && i < rx_q.size(); i++)
      check_val($sformatf("wrap_%0d", i), rx_q[i], 9'h100 | 9'(i));
    check_val("max_count", max_cnt, DEPTH);
    wait_idle(20*P);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
